// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, the execution FSM state enum and the
// default datapath width.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_MUL  = 4'b0100;
  localparam logic [3:0] ALU_MULH = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier on operand magnitudes. The sign is restored on
// the final iteration, so product_o is the full signed 2*XLEN product in the
// cycle that done_o is high.
module alu_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic              done_o,
  output logic [2*XLEN-1:0] product_o
);

  localparam int CW = $clog2(XLEN);

  logic              busy_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic              neg_q;
  logic [2*XLEN-1:0] prod_q;
  logic [2*XLEN-1:0] prod_d;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;

  assign a_mag  = a_i[XLEN-1] ? -a_i : a_i;
  assign b_mag  = b_i[XLEN-1] ? -b_i : b_i;
  assign prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);

  assign done_o    = busy_q & (cnt_q == CW'(XLEN - 1));
  assign product_o = neg_q ? -prod_d : prod_d;

  // Latch magnitudes on start, then accumulate one multiplier bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{XLEN{1'b0}}, a_mag};
      mplier_q <= b_mag;
      neg_q    <= a_i[XLEN-1] ^ b_i[XLEN-1];
      prod_q   <= '0;
    end else if (busy_q) begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == CW'(XLEN - 1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execution unit with valid/ready handshake on both sides.
// Build option ALU_EXEC_FAST_MUL_EN: when defined, MUL/MULH use a combinational
// product and complete in one cycle; otherwise alu_mul_iter runs XLEN cycles.
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  alu_state_e      state_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            lt_q;
  logic            illegal_q;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] diff;
  logic            ovf;
  logic            accept;
  logic [XLEN-1:0] result_d;
  logic            lt_d;
  logic            illegal_d;

  assign shamt  = op_b[SHW-1:0];
  assign diff   = op_a - op_b;
  assign ovf    = (op_a[XLEN-1] ^ op_b[XLEN-1]) & (op_a[XLEN-1] ^ diff[XLEN-1]);

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign lt        = lt_q;
  assign illegal   = illegal_q;

`ifdef ALU_EXEC_FAST_MUL_EN
  logic signed [2*XLEN-1:0] prod_fast;
  assign prod_fast = $signed({{XLEN{op_a[XLEN-1]}}, op_a}) *
                     $signed({{XLEN{op_b[XLEN-1]}}, op_b});
`else
  logic              is_mul_d;
  logic              mulh_q;
  logic              mul_start;
  logic              mul_done;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   mul_res;

  assign mul_start = accept & is_mul_d;
  assign mul_res   = mulh_q ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];

  alu_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mul_start),
    .a_i      (op_a),
    .b_i      (op_b),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );
`endif

  // Single-cycle result and flags for the presented operation code.
  always_comb begin
    result_d  = '0;
    lt_d      = 1'b0;
    illegal_d = 1'b0;
`ifndef ALU_EXEC_FAST_MUL_EN
    is_mul_d  = 1'b0;
`endif
    case (alu_ctrl)
      ALU_AND: result_d = op_a & op_b;
      ALU_OR:  result_d = op_a | op_b;
      ALU_ADD: result_d = op_a + op_b;
      ALU_SLL: result_d = op_a << shamt;
      ALU_SUB: begin
        result_d = diff;
        lt_d     = diff[XLEN-1] ^ ovf;
      end
      ALU_XOR: result_d = op_a ^ op_b;
      ALU_SRL: result_d = op_a >> shamt;
      ALU_SRA: result_d = $unsigned($signed(op_a) >>> shamt);
`ifdef ALU_EXEC_FAST_MUL_EN
      ALU_MUL:  result_d = prod_fast[XLEN-1:0];
      ALU_MULH: result_d = prod_fast[2*XLEN-1:XLEN];
`else
      ALU_MUL, ALU_MULH: is_mul_d = 1'b1;
`endif
      default: illegal_d = 1'b1;
    endcase
  end

  // Execution FSM: accept, optionally iterate, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      lt_q      <= 1'b0;
      illegal_q <= 1'b0;
`ifndef ALU_EXEC_FAST_MUL_EN
      mulh_q    <= 1'b0;
`endif
    end else if (accept) begin
`ifndef ALU_EXEC_FAST_MUL_EN
      if (is_mul_d) begin
        state_q <= ST_MUL;
        mulh_q  <= (alu_ctrl == ALU_MULH);
      end else begin
`endif
        state_q   <= ST_DONE;
        result_q  <= result_d;
        zero_q    <= (result_d == '0);
        lt_q      <= lt_d;
        illegal_q <= illegal_d;
`ifndef ALU_EXEC_FAST_MUL_EN
      end
    end else if ((state_q == ST_MUL) && mul_done) begin
      state_q   <= ST_DONE;
      result_q  <= mul_res;
      zero_q    <= (mul_res == '0);
      lt_q      <= 1'b0;
      illegal_q <= 1'b0;
`endif
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_q <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: the driver pushes expected results, a negedge
// monitor pops and compares them whenever a result is presented.
module tb_alu_exec;
  import alu_pkg::*;

  localparam int XLEN = 32;
`ifdef ALU_EXEC_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = XLEN;
`endif

  typedef struct {
    logic [XLEN-1:0] res;
    logic            z;
    logic            lt;
    logic            ill;
    int              lat;
    int              acc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            lt;
  logic            illegal;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   edge_cnt = 0;
  int   last_acc = 0;
  bit   seen_cur = 1'b0;
  bit   rand_rdy = 1'b0;

  alu_exec #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .lt       (lt),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #2;
      out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Reference behaviour from the operation definitions.
  function automatic exp_t model(input logic [3:0] c, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    exp_t   e;
    longint p;
    int     sh;
    e.res = '0; e.lt = 1'b0; e.ill = 1'b0; e.lat = 0; e.acc = 0;
    sh = int'(b[4:0]);
    p  = longint'($signed(a)) * longint'($signed(b));
    case (c)
      4'h0: e.res = a & b;
      4'h1: e.res = a | b;
      4'h2: e.res = a + b;
      4'h3: e.res = a << sh;
      4'h4: begin e.res = p[31:0];  e.lat = MUL_LAT; end
      4'h5: begin e.res = p[63:32]; e.lat = MUL_LAT; end
      4'h6: begin e.res = a - b; e.lt = ($signed(a) < $signed(b)); end
      4'h8: e.res = a ^ b;
      4'hA: e.res = a >> sh;
      4'hB: e.res = $unsigned($signed(a) >>> sh);
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Call at posedge+1; returns at posedge+1 of the accept edge.
  task automatic issue(input logic [3:0] c, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input exp_t e);
    int n;
    n = 0;
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: in_ready never rose, expected 1");
        finish_sim();
      end
    end
    @(posedge clk);
    #1;
    e.acc = edge_cnt;
    last_acc = edge_cnt;
    sb.push_back(e);
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom);
    op_a = $urandom;
    op_b = $urandom;
  endtask

  task automatic dir(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [XLEN-1:0] res, input logic z, input logic l, input logic ill);
    exp_t e;
    e.res = res; e.z = z; e.lt = l; e.ill = ill; e.acc = 0;
    e.lat = (c == ALU_MUL || c == ALU_MULH) ? MUL_LAT : 0;
    issue(c, a, b, e);
  endtask

  function automatic logic [XLEN-1:0] pick();
    logic [XLEN-1:0] corners [5];
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_result"},    64'(result),    64'd0);
    chk({tag, "_zero"},      64'(zero),      64'd1);
    chk({tag, "_lt"},        64'(lt),        64'd0);
    chk({tag, "_illegal"},   64'(illegal),   64'd0);
  endtask

  // Monitor: compare every presented result; pop when it is taken.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: result 0x%0h with empty scoreboard", result);
      end else begin
        e = sb[0];
        if (!seen_cur) chk("latency_edges", 64'(edge_cnt - e.acc), 64'(e.lat));
        chk("result",  64'(result),  64'(e.res));
        chk("zero",    64'(zero),    64'(e.z));
        chk("lt",      64'(lt),      64'(e.lt));
        chk("illegal", 64'(illegal), 64'(e.ill));
        if (out_ready) begin
          void'(sb.pop_front());
          seen_cur = 1'b0;
        end else begin
          seen_cur = 1'b1;
        end
      end
    end
  end

  initial begin
    int a1;
    int n;
    logic [3:0] c;
    rst_n = 1'b0; in_valid = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0; out_ready = 1'b1;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    dir(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    a1 = last_acc;
    dir(ALU_SUB, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("back_to_back_accept", 64'(last_acc - a1), 64'd1);
    dir(ALU_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    dir(ALU_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
    dir(ALU_SRL, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1'b0, 1'b0);
    dir(4'hF, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b0, 1'b1);

    // MULH with the consumer stalled, then a new op issued as it releases.
    @(posedge clk); #1;
    out_ready = 1'b0;
    dir(ALU_MULH, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < MUL_LAT; i++) begin
      @(negedge clk);
      chk("mul_busy_in_ready", 64'(in_ready), 64'd0);
      chk("mul_busy_out_valid", 64'(out_valid), 64'd0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    dir(ALU_AND, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0, 1'b0);
    dir(ALU_MUL, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a multiply.
    dir(ALU_MUL, 32'd7, 32'd9, 32'd63, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    seen_cur = 1'b0;
    #1;
    chk_reset_outputs("midmul_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("post_reset_out_valid", 64'(out_valid), 64'd0);
    end
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    dir(ALU_MUL, 32'd7, 32'd9, 32'd63, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with random consumer back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [XLEN-1:0] ra;
      logic [XLEN-1:0] rb;
      c  = 4'($urandom_range(0, 15));
      ra = pick();
      rb = pick();
      issue(c, ra, rb, model(c, ra, rb));
    end
    rand_rdy = 1'b0;
    @(posedge clk); #3;
    out_ready = 1'b1;

    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    finish_sim();
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execution unit consuming the 4-bit `alu_ctrl` code from ALU control decode, together with operands from the register-read/immediate mux. It performs every decoded operation and returns a result with zero and signed-less-than flags for writeback and branch resolution. Single-cycle ops complete in one cycle. MUL/MULH use an iterative shift-add multiplier behind a valid/ready handshake, so the pipeline can stall on multiplies.

## Interface
- `XLEN`, 32, operand/result width. Legal values are 32 and 64. Shift amount width is `$clog2(XLEN)`.
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `in_valid`  in  1  operation request
- `in_ready`  out  1  unit can accept a request this cycle
- `alu_ctrl`  in  4  operation code
- `op_a`  in  XLEN  operand A (rs1)
- `op_b`  in  XLEN  operand B (rs2 or immediate)
- `out_valid`  out  1  result, flags and `illegal` are valid
- `out_ready`  in  1  consumer accepts the result
- `result`  out  XLEN  operation result
- `zero`  out  1  `result == 0`
- `lt`  out  1  signed `op_a < op_b`; meaningful for SUB only, 0 otherwise
- `illegal`  out  1  unrecognised `alu_ctrl` was accepted

## Operation
- Codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 SLL
  - 0100 MUL (low XLEN bits)
  - 0101 MULH (signed×signed, high XLEN bits)
  - 0110 SUB
  - 1000 XOR
  - 1010 SRL
  - 1011 SRA
  - Any other code (including 1111): `result`=0, `illegal`=1, completes as a single-cycle op.
- Shift amount is `op_b[$clog2(XLEN)-1:0]`; upper bits are ignored. ADD/SUB wrap modulo 2^XLEN.
- `lt` = `diff[XLEN-1] ^ ovf`, where `ovf` is the signed overflow of `op_a - op_b`.
- States:
  - IDLE: `in_ready`=1.
  - MUL: iterating; `in_ready`=0, `out_valid`=0.
  - DONE: `out_valid`=1.
- Transitions:
  - IDLE, accept, single-cycle op → DONE with the result registered.
  - IDLE, accept, MUL/MULH → MUL. Latch |a| and |b|, the sign-difference bit and the op select; clear the 2·XLEN-bit product and the counter.
  - MUL: each cycle, if the multiplier LSB is set, add the multiplicand to the product; shift; increment the counter. After iteration XLEN-1 → DONE. On entry to DONE, the product is negated if the signs differed, then the low or high half is selected.
  - DONE and `out_ready`=0: hold all outputs stable.
  - DONE and `out_ready`=1: if `in_valid` (`in_ready`=1 here), accept the new op per the IDLE rules; otherwise → IDLE.
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`).
- Signedness rule: MUL low bits are sign-independent, so the abs/negate path is applied to MUL as well for a single datapath.

## Timing
- Reset values:
  - state IDLE
  - `in_ready`=1
  - `out_valid`=0
  - `result`=0
  - `zero`=1
  - `lt`=0
  - `illegal`=0
  - counter and product 0
- Single-cycle op accepted at edge t: `out_valid` is high after edge t (latency 1).
- MUL/MULH accepted at edge t: `out_valid` is high after edge t+XLEN (latency XLEN+1). No early termination.
- Back-to-back single-cycle ops with `out_ready`=1 sustain one result per cycle.
- `rst_n` asserted mid-multiply: the operation is discarded immediately and all outputs take their reset values. No result is produced after release.
- Request inputs are sampled only on an accept edge; later changes to `op_a`/`op_b` do not affect an in-flight op.

## Configuration
- `ALU_EXEC_FAST_MUL_EN`
  - Defined: MUL/MULH use a combinational signed `XLEN×XLEN` product, registered like any single-cycle op. Latency is 1 and the MUL state and counter are not compiled.
  - Undefined: the iterative multiplier as specified above, with latency XLEN+1.
- Handshake semantics are identical in both builds.

## Structure
- Shared package `alu_pkg`:
  - `alu_ctrl` code localparams, shared with ALU control decode
  - state enum (IDLE, MUL, DONE)
  - `XLEN` default
- Sub-module `alu_mul_iter`:
  - Contains the counter, the shift-add product register and sign fixup.
  - Has start/done pulses and a 2·XLEN product output.
  - Instantiated only when `ALU_EXEC_FAST_MUL_EN` is undefined.

## Test plan
- ADD 0x7FFFFFFF+1 → `result` 0x80000000, `zero`=0, latency 1. SUB 5-5 → 0, `zero`=1, `lt`=0.
- SUB 0x80000000-1 → `lt`=1 (overflow case). SRA 0x80000000 by `op_b`=0x24 (shamt 4) → 0xF8000000. SRL of the same → 0x08000000.
- MULH -2×3 → 0xFFFFFFFF; MUL → 0xFFFFFFFA. `out_valid` after exactly 33 edges, `in_ready`=0 throughout.
- Hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0. Raise `out_ready` with `in_valid` and AND 0xF0&0x3C → next result 0x30 one cycle later.
- Pulse `rst_n` low at iteration 10 of MUL 7×9 → outputs at reset values. After release no `out_valid`, `in_ready`=1.
- `alu_ctrl`=1111 → `result` 0, `illegal`=1, latency 1. Repeat MUL 7×9 with `ALU_EXEC_FAST_MUL_EN` defined → 63 with latency 1.
